// File: rtl/mmio_uart_tx_port.sv
// Memory-mapped UART transmitter: a 4-entry TX FIFO drained by an 8N1 serializer,
// plus status, baud divisor and synchronized input-port registers.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for one bit time
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); pops the next byte back-to-back if one is queued
module mmio_uart_tx_port #(
    parameter logic [31:0] BASE_ADDR       = 32'hFFFF_0000,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd434,
    parameter int          FIFO_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [7:0]  PortIn,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        tx,
    output logic        TxEmptyIrq
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_next;
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic        overflow;
    logic [15:0] divisor, div_lat, timer;
    logic [7:0]  shift;
    logic [2:0]  bit_idx;
    logic [7:0]  sync1, sync2;

    logic        tx_next, pop, start_frame;
    logic [15:0] timer_next, div_lat_next;
    logic [7:0]  shift_next;
    logic [2:0]  bit_idx_next;

    logic [1:0]  offset;
    logic        wr_sel, push, accept, full, empty, busy;
    logic        unused_bits;

    assign offset      = Address[3:2];
    assign Hit         = Address[31:4] == BASE_ADDR[31:4];
    assign wr_sel      = MemWrite & Hit;
    assign push        = wr_sel && (offset == 2'd0);
    assign full        = count == 3'(FIFO_DEPTH);
    assign empty       = count == 3'd0;
    assign busy        = state != IDLE;
    assign accept      = push && (!full || pop);
    assign unused_bits = ^{Address[1:0], WriteData[31:16]};

    always_comb begin
        state_next   = state;
        tx_next      = tx;
        timer_next   = timer;
        div_lat_next = div_lat;
        shift_next   = shift;
        bit_idx_next = bit_idx;
        start_frame  = 1'b0;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (!empty) start_frame = 1'b1;
            end
            START: begin
                if (timer == 16'd0) begin
                    tx_next      = shift[0];
                    bit_idx_next = 3'd0;
                    timer_next   = div_lat - 16'd1;
                    state_next   = DATA;
                end else begin
                    timer_next = timer - 16'd1;
                end
            end
            DATA: begin
                if (timer == 16'd0) begin
                    timer_next = div_lat - 16'd1;
                    if (bit_idx == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        shift_next   = {1'b0, shift[7:1]};
                        tx_next      = shift[1];
                    end
                end else begin
                    timer_next = timer - 16'd1;
                end
            end
            STOP: begin
                if (timer == 16'd0) begin
                    if (!empty) start_frame = 1'b1;
                    else        state_next  = IDLE;
                end else begin
                    timer_next = timer - 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
        // The divisor is captured here so a mid-frame DIVISOR write only affects later frames.
        if (start_frame) begin
            pop          = 1'b1;
            shift_next   = fifo_mem[rd_ptr];
            div_lat_next = divisor;
            timer_next   = divisor - 16'd1;
            tx_next      = 1'b0;
            state_next   = START;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            tx         <= 1'b1;
            timer      <= 16'd0;
            div_lat    <= DEFAULT_DIVISOR;
            shift      <= 8'd0;
            bit_idx    <= 3'd0;
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            count      <= 3'd0;
            overflow   <= 1'b0;
            divisor    <= DEFAULT_DIVISOR;
            sync1      <= 8'd0;
            sync2      <= 8'd0;
            TxEmptyIrq <= 1'b1;
        end else begin
            state   <= state_next;
            tx      <= tx_next;
            timer   <= timer_next;
            div_lat <= div_lat_next;
            shift   <= shift_next;
            bit_idx <= bit_idx_next;
            if (accept) wr_ptr <= wr_ptr + 2'd1;
            if (pop)    rd_ptr <= rd_ptr + 2'd1;
            case ({accept, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (push && full && !pop)
                overflow <= 1'b1;
            else if (wr_sel && (offset == 2'd1) && WriteData[3])
                overflow <= 1'b0;
            if (wr_sel && (offset == 2'd2))
                divisor <= (WriteData[15:0] == 16'd0) ? 16'd1 : WriteData[15:0];
            sync1      <= PortIn;
            sync2      <= sync1;
            TxEmptyIrq <= empty && (state == IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) fifo_mem[wr_ptr] <= WriteData[7:0];
    end

    always_comb begin
        ReadData = 32'd0;
        if (Hit && MemRead) begin
            case (offset)
                2'd1:    ReadData = {25'd0, count, overflow, busy, empty, full};
                2'd2:    ReadData = {16'd0, divisor};
                2'd3:    ReadData = {24'd0, sync2};
                default: ReadData = 32'd0;
            endcase
        end
    end

endmodule
